// File: rtl/instruction_fetch.sv
// instruction_fetch: program counter, memory read handshake and 2-entry prefetch queue
module instruction_fetch #(
  parameter int ADDR_W = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic clk,
  input  logic reset,
  input  logic pc_inc,
  input  logic halt,
  input  logic jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instruction,
  output logic instr_valid,
  output logic [ADDR_W-1:0] instr_pc
);
  typedef enum logic [1:0] {IDLE, WAIT, DISCARD, HALTED} state_t;
  state_t state, state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic [31:0] q_data [2];
  logic [ADDR_W-1:0] q_addr [2];
  logic head;
  logic [1:0] count;
  logic push, pop, issue;
  assign pop = pc_inc && instr_valid && !jump;
  assign push = state == WAIT && mem_ack && !jump;
  assign issue = state == IDLE && !halt && !jump && (count != 2'd2 || pop);
  // state register
  always_ff @(posedge clk) state <= reset ? IDLE : state_nxt;
  // next state: a jump while idle waits one cycle so the request uses the new PC
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = halt ? HALTED : issue ? WAIT : IDLE;
      WAIT:    state_nxt = mem_ack ? IDLE : jump ? DISCARD : WAIT;
      DISCARD: state_nxt = mem_ack ? IDLE : DISCARD;
      HALTED:  state_nxt = halt ? HALTED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  // outputs: request while a read is outstanding, queue head otherwise NOP
  always_comb begin
    mem_req = state == WAIT || state == DISCARD;
    instr_valid = count != 2'd0;
    instruction = instr_valid ? q_data[head] : NOP_WORD;
    instr_pc = instr_valid ? q_addr[head] : fetch_pc;
  end
  // fetch PC and the address latched for the outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      mem_addr <= RESET_PC;
    end else begin
      if (issue) mem_addr <= fetch_pc;
      if (jump) fetch_pc <= jump_target;
      else if (push) fetch_pc <= fetch_pc + 1'b1;
    end
  end
  // queue occupancy and head pointer; jump flushes
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= 1'b0;
      count <= 2'd0;
    end else if (jump) begin
      count <= 2'd0;
    end else begin
      count <= count + {1'b0, push} - {1'b0, pop};
      head <= head ^ pop;
    end
  end
  // queue storage: write slot is the head offset by occupancy (head itself when full)
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[head ^ count[0]] <= mem_rdata;
      q_addr[head ^ count[0]] <= mem_addr;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: random and directed stimulus against a queue-based reference model
module tb_instruction_fetch;
  localparam int AW = 16;
  logic clk = 1'b0;
  logic reset, pc_inc, halt, jump, mem_req, mem_ack, instr_valid;
  logic [AW-1:0] jump_target, mem_addr, instr_pc;
  logic [31:0] mem_rdata, instruction;
  logic w_req, w_valid;
  logic [3:0] w_addr, w_ipc;
  logic [31:0] w_instr;
  int passed = 0, total = 0;
  always #5 clk = ~clk;

  instruction_fetch u_dut (
    .clk(clk), .reset(reset), .pc_inc(pc_inc), .halt(halt), .jump(jump),
    .jump_target(jump_target), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .instruction(instruction),
    .instr_valid(instr_valid), .instr_pc(instr_pc)
  );

  instruction_fetch #(.ADDR_W(4), .RESET_PC(4'd14)) u_w (
    .clk(clk), .reset(reset), .pc_inc(1'b1), .halt(1'b0), .jump(1'b0),
    .jump_target(4'd0), .mem_req(w_req), .mem_addr(w_addr),
    .mem_ack(w_req), .mem_rdata({28'd0, w_addr}), .instruction(w_instr),
    .instr_valid(w_valid), .instr_pc(w_ipc)
  );

  // reference model: expected queue contents, next fetch address, outstanding request
  logic [47:0] mq[$];
  logic [AW-1:0] exp_pc, cap, d_tgt, jaddr;
  bit pend, drop, busy, acked_prev, last_halt;
  bit rnd, d_rst, d_inc, d_halt, d_jump, jaddr_en, jon_ack;
  int wcnt, pops, dmin, dmax, p_spur;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cycle();
    logic req, ack;
    logic [AW-1:0] a;
    @(negedge clk);
    req = mem_req;
    a = mem_addr;
    check("valid", 32'(instr_valid), 32'(mq.size() != 0));
    check("instr", instruction, mq.size() != 0 ? mq[0][47:16] : 32'h0);
    if (mq.size() != 0) check("ipc", 32'(instr_pc), 32'(mq[0][15:0]));
    if (acked_prev) check("req_gap", 32'(req), 0);
    if (pend) check("req_kept", 32'(req), 1);
    if (req && pend) check("req_hold", 32'(a), 32'(cap));
    if (req && !pend) begin
      check("req_addr", 32'(a), 32'(exp_pc));
      check("req_room", 32'(mq.size() <= 1), 1);
      check("req_halt", 32'(last_halt), 0);
    end
    if (!req) busy = 0;
    if (req && !busy) begin
      busy = 1;
      wcnt = $urandom_range(dmax, dmin);
    end
    ack = req ? wcnt == 0 : $urandom_range(99) < p_spur;
    if (req && !ack) wcnt--;
    if (ack) busy = 0;
    mem_ack = ack;
    mem_rdata = req ? 32'hA000 + 32'(a) : $urandom;
    reset = d_rst || (rnd && $urandom_range(999) < 3);
    pc_inc = rnd ? $urandom_range(99) < 60 : d_inc;
    halt = rnd ? $urandom_range(99) < 10 : d_halt;
    jump_target = rnd ? AW'($urandom) : d_tgt;
    jump = rnd ? $urandom_range(99) < 5 : d_jump;
    if (jaddr_en && req && a == jaddr) begin
      jump = 1;
      jaddr_en = 0;
    end
    if (jon_ack && req && ack) begin
      jump = 1;
      jon_ack = 0;
    end
    @(posedge clk);
    acked_prev = 0;
    if (reset) begin
      mq.delete();
      exp_pc = '0;
      pend = 0;
      drop = 0;
    end else begin
      if (req && !pend) begin
        pend = 1;
        drop = 0;
        cap = a;
      end
      if (req && jump) drop = 1;
      if (pc_inc && mq.size() != 0 && !jump) begin
        void'(mq.pop_front());
        pops++;
      end
      if (req && ack) begin
        pend = 0;
        acked_prev = 1;
        if (!drop) begin
          mq.push_back({32'hA000 + 32'(a), a});
          exp_pc = AW'(a + 1);
        end
      end
      if (jump) begin
        mq.delete();
        exp_pc = jump_target;
      end
    end
    last_halt = halt || reset;
  endtask

  task automatic tick();
    cycle();
    #1;
  endtask

  // narrow instance: collect its first four requests and delivered words
  logic [3:0] w_reqs[$], w_pcs[$];
  logic [31:0] w_ins[$];
  bit w_prev;
  logic [3:0] w_exp [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
  always @(negedge clk) begin
    if (w_req && !w_prev && w_reqs.size() < 4) w_reqs.push_back(w_addr);
    if (w_valid && w_pcs.size() < 4) begin
      w_pcs.push_back(w_ipc);
      w_ins.push_back(w_instr);
    end
    w_prev = w_req;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rnd = 0; d_rst = 1; d_inc = 0; d_halt = 0; d_jump = 0; d_tgt = '0;
    jaddr_en = 0; jaddr = '0; jon_ack = 0; dmin = 0; dmax = 0; p_spur = 0;
    pend = 0; drop = 0; busy = 0; acked_prev = 0; last_halt = 1; exp_pc = '0; cap = '0;
    reset = 1; pc_inc = 0; halt = 0; jump = 0; jump_target = '0; mem_ack = 0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    tick();
    check("rst_req", 32'(mem_req), 0);
    check("rst_valid", 32'(instr_valid), 0);
    check("rst_instr", instruction, 32'h0);
    check("rst_ipc", 32'(instr_pc), 0);
    // streaming with immediate acks: one word every two cycles
    d_rst = 0; d_inc = 1; pops = 0;
    repeat (40) tick();
    check("thruput", 32'(pops >= 19), 1);
    // consumer stalled: queue fills to two words, then fetch stops
    d_rst = 1; tick(); d_rst = 0; d_inc = 0;
    repeat (10) tick();
    check("stall_req", 32'(mem_req), 0);
    check("stall_valid", 32'(instr_valid), 1);
    check("stall_head", instruction, 32'hA000);
    d_inc = 1; tick(); d_inc = 0;
    check("stall_next", instruction, 32'hA001);
    for (int n = 0; n < 8 && !mem_req; n++) tick();
    check("refill_req", 32'(mem_req), 1);
    check("refill_addr", 32'(mem_addr), 2);
    // jump while waiting on address 3 with a slow memory
    dmin = 4; dmax = 4; d_inc = 1; jaddr = 16'd3; d_tgt = 16'h0100; jaddr_en = 1;
    for (int n = 0; n < 60 && jaddr_en; n++) tick();
    check("jmp_fired", 32'(jaddr_en), 0);
    for (int n = 0; n < 30 && !(mem_req && mem_addr == 16'h0100); n++) tick();
    check("jmp_req", 32'(mem_req), 1);
    check("jmp_addr", 32'(mem_addr), 32'h0100);
    for (int n = 0; n < 20 && !instr_valid; n++) tick();
    check("jmp_instr", instruction, 32'hA100);
    check("jmp_pc", 32'(instr_pc), 32'h0100);
    // jump coinciding with the ack: returned word never shows up
    dmin = 0; dmax = 2; d_tgt = 16'h0200; jon_ack = 1;
    for (int n = 0; n < 30 && jon_ack; n++) tick();
    check("ja_fired", 32'(jon_ack), 0);
    check("ja_valid", 32'(instr_valid), 0);
    for (int n = 0; n < 10 && !mem_req; n++) tick();
    check("ja_addr", 32'(mem_addr), 32'h0200);
    // halt with one word buffered
    d_rst = 1; tick(); d_rst = 0; d_inc = 0; dmin = 0; dmax = 0;
    for (int n = 0; n < 10 && !instr_valid; n++) tick();
    check("halt_pre", 32'(instr_valid), 1);
    d_halt = 1;
    repeat (2) tick();
    for (int n = 0; n < 8; n++) begin
      tick();
      check("halt_req", 32'(mem_req), 0);
      check("halt_head", instruction, 32'hA000);
    end
    d_halt = 0;
    for (int n = 0; n < 8 && !mem_req; n++) tick();
    check("resume_req", 32'(mem_req), 1);
    check("resume_addr", 32'(mem_addr), 1);
    // random traffic: variable latency, jumps, halts, resets, stray acks
    rnd = 1; dmin = 0; dmax = 3; p_spur = 20;
    repeat (3000) tick();
    rnd = 0; d_halt = 1; d_inc = 0; p_spur = 0;
    tick();
    // narrow PC wraps 14,15,0,1
    check("w_nreq", 32'(w_reqs.size()), 4);
    check("w_npc", 32'(w_pcs.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < w_reqs.size()) check($sformatf("w_req%0d", i), 32'(w_reqs[i]), 32'(w_exp[i]));
      if (i < w_pcs.size()) begin
        check($sformatf("w_pc%0d", i), 32'(w_pcs[i]), 32'(w_exp[i]));
        check($sformatf("w_ins%0d", i), w_ins[i], 32'(w_exp[i]));
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Upstream fetch stage feeding the control path. It holds the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers returned words in a 2-entry prefetch queue. The head of the queue is presented as `instruction` to the control path. The control path's `program_counter_inc` consumes that head; jumps redirect the PC and flush the queue.

Parameters:
ADDR_W, 16, width of the word-addressed program counter and memory address
RESET_PC, 0, PC value loaded on reset
NOP_WORD, 32'h00000000, value driven on `instruction` while no valid word is buffered

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
pc_inc  input  1  from control path `program_counter_inc`: consume current instruction
halt  input  1  control path stopped (invalid instruction); stop fetching
jump  input  1  load `jump_target` into PC and flush queue
jump_target  input  ADDR_W  new word address
mem_req  output  1  read request, held until acknowledged
mem_addr  output  ADDR_W  word address of the request, stable while `mem_req` is high
mem_ack  input  1  read data valid on `mem_rdata` this cycle
mem_rdata  input  32  instruction word returned
instruction  output  32  queue head, or NOP_WORD when empty
instr_valid  output  1  queue non-empty
instr_pc  output  ADDR_W  address of the word on `instruction`

Behaviour:
- Reset (synchronous, priority over all inputs):
  - fetch_pc=RESET_PC; queue empty; state=IDLE.
  - mem_req=0, instr_valid=0, instruction=NOP_WORD, instr_pc=RESET_PC.
- State machine. States are IDLE, WAIT, DISCARD, HALTED.
  - IDLE:
    - If halt, go to HALTED.
    - Else if the queue has a free slot (counting a same-cycle pop), assert mem_req with mem_addr=fetch_pc and go to WAIT.
  - WAIT:
    - mem_req stays high and mem_addr stays fixed until mem_ack.
    - On mem_ack: push {mem_rdata, mem_addr}, fetch_pc+=1, deassert mem_req the following cycle, return to IDLE.
    - On mem_ack the request drops for at least one cycle, giving a maximum of 1 word per 2 cycles.
  - DISCARD (entered on jump while WAIT):
    - mem_req stays high until mem_ack.
    - The returned word is dropped, not pushed.
    - Then go to IDLE, where the fetch from the new PC is issued.
  - HALTED:
    - mem_req=0; no requests issued.
    - Stays HALTED while halt=1; returns to IDLE when halt=0.
    - Queue contents are retained.
- Queue: 2 entries, FIFO order.
  - instruction/instr_pc/instr_valid are driven directly from the head. This is combinational from registered state, so there is zero-cycle visibility after a push registers.
  - Pop occurs when pc_inc=1 and instr_valid=1.
  - pc_inc while empty is ignored: no pop, no error.
  - Simultaneous push and pop while full: legal, count stays 2.
  - Push is never attempted while full without a pop; the request gating guarantees this.
- Jump (priority over pc_inc and over the push in the same cycle):
  - fetch_pc<=jump_target.
  - Queue flushed; instr_valid=0 next cycle.
  - If a request is outstanding, go to DISCARD (from WAIT). If the mem_ack arrives in the same cycle as the jump, the data is dropped and the state goes directly to IDLE.
- Halt: a request already in WAIT completes and its word is pushed; after that the state goes to HALTED. Jump while halted is still accepted: PC is loaded and the queue flushed.
- PC arithmetic: ADDR_W-bit unsigned, wraps from 2^ADDR_W-1 to 0 with no flag.
- Reset asserted mid-transaction: mem_req drops next cycle. Any late mem_ack after reset is ignored (state IDLE, not WAIT).

Test Plan:
- Reset, memory acks 1 cycle after req with rdata=addr+32'hA000, pc_inc held 1 -> instruction sequence A000,A001,A002…; instr_pc 0,1,2…; no gaps beyond the 2-cycle request spacing.
- pc_inc=0 for 10 cycles -> exactly 2 words buffered (A000,A001), mem_req low; after one pc_inc a single new request for addr 2.
- Jump to 0x0100 while WAIT on addr 3, ack delayed 4 cycles -> word for addr 3 dropped; next mem_addr=0x0100; first instruction A100, instr_pc=0x0100.
- Jump asserted in the same cycle as mem_ack -> acked word not visible; instr_valid=0 next cycle; next request at jump_target.
- halt=1 with queue holding 1 word -> no further mem_req; head stays stable; halt=0 -> fetching resumes at next fetch_pc.
- ADDR_W=4, RESET_PC=14 -> fetch addresses 14,15,0,1; instr_pc wraps accordingly.
